// File: rtl/dlycal_pkg.sv
// rtl/dlycal_pkg.sv - shared constants, FSM state type and delay clamp for the delay calibrator
package dlycal_pkg;

  localparam int NCHAN      = 4;
  localparam int NREGS      = 10;
  localparam int DBITS      = 4;
  localparam int WBITS      = 16;
  localparam int CBITS      = 16;
  localparam int CHBITS     = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int SETTLE_CYC = NREGS + 2;
  localparam int TBITS      = $clog2(SETTLE_CYC);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    EVAL,
    DONE
  } state_t;

  // Tap indices above the last physical delay stage select the last stage.
  function automatic logic [DBITS-1:0] clamp_delay(input logic [DBITS-1:0] v);
    return (int'(v) > NREGS - 1) ? DBITS'(NREGS - 1) : v;
  endfunction

endpackage

// File: rtl/coinc_window_counter.sv
// rtl/coinc_window_counter.sv - count-window down-counter with saturating coincidence counter
module coinc_window_counter
  import dlycal_pkg::*;
#(
  parameter int LEN_W = WBITS,
  parameter int CNT_W = CBITS
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [LEN_W-1:0] Len,
  input  logic             Hit,
  output logic [CNT_W-1:0] Cnt,
  output logic             Expired
);

  logic [LEN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  // Load arms a window of max(Len,1) cycles; hits only count while cycles remain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rem <= '0;
      r_cnt <= '0;
    end else if (Load) begin
      r_rem <= (Len == '0) ? LEN_W'(1) : Len;
      r_cnt <= '0;
    end else if (r_rem != '0) begin
      r_rem <= r_rem - 1'b1;
      if (Hit && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Cnt     = r_cnt;
  // High during the last cycle of the window: the window closes on this edge.
  assign Expired = (r_rem == LEN_W'(1));

endmodule

// File: rtl/delay_calibrator.sv
// rtl/delay_calibrator.sv - delay-select register file with automatic coincidence sweep calibration
module delay_calibrator
  import dlycal_pkg::*;
(
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Start,
  input  logic                         Abort,
  input  logic [WBITS-1:0]             WindowLen,
  input  logic                         CfgWe,
  input  logic [CHBITS-1:0]            CfgChan,
  input  logic [DBITS-1:0]             CfgDelay,
  input  logic [NCHAN-1:0]             DlayChann,
  output logic [NCHAN-1:0][DBITS-1:0]  Delays,
  output logic                         Busy,
  output logic                         Done,
  output logic [NCHAN-1:0]             NoCoinc
);

  state_t                      r_state;
  logic [NCHAN-1:0][DBITS-1:0] r_delays;
  logic [NCHAN-1:0][DBITS-1:0] r_snap;
  logic [NCHAN-1:0]            r_nocoinc;
  logic                        r_busy;
  logic                        r_done;
  logic [CHBITS-1:0]           r_c;
  logic [DBITS-1:0]            r_d;
  logic [DBITS-1:0]            r_bestd;
  logic [CBITS-1:0]            r_best;
  logic [TBITS-1:0]            r_tmr;

  logic [CBITS-1:0]            w_cnt;
  logic                        w_expired;
  logic                        w_load;
  logic                        w_hit;
  logic                        w_abort;
  logic                        w_better;
  logic [CBITS-1:0]            w_fin_best;
  logic [DBITS-1:0]            w_fin_bestd;

  assign w_hit       = DlayChann[0] & DlayChann[r_c];
  assign w_abort     = Abort && (r_state inside {SETTLE, COUNT, EVAL});
  assign w_load      = (r_state == SETTLE) && (r_tmr == TBITS'(SETTLE_CYC - 1)) && !Abort;
  // Strictly greater keeps the lower tap on equal counts.
  assign w_better    = (w_cnt > r_best);
  assign w_fin_best  = w_better ? w_cnt : r_best;
  assign w_fin_bestd = w_better ? r_d : r_bestd;

  coinc_window_counter #(
    .LEN_W (WBITS),
    .CNT_W (CBITS)
  ) u_win (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Load    (w_load),
    .Len     (WindowLen),
    .Hit     (w_hit),
    .Cnt     (w_cnt),
    .Expired (w_expired)
  );

  // Calibration sequencer: owns the delay selects, snapshot and all status outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= IDLE;
      r_delays  <= '0;
      r_snap    <= '0;
      r_nocoinc <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_c       <= '0;
      r_d       <= '0;
      r_bestd   <= '0;
      r_best    <= '0;
      r_tmr     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_delays  <= r_snap;
        r_busy    <= 1'b0;
        r_nocoinc <= '0;
        r_state   <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            // Start wins over a simultaneous manual write.
            if (Start) begin
              r_snap      <= r_delays;
              r_delays[0] <= '0;
              if (NCHAN > 1)
                r_delays[1] <= '0;
              r_c       <= CHBITS'(1);
              r_d       <= '0;
              r_best    <= '0;
              r_bestd   <= '0;
              r_tmr     <= '0;
              r_nocoinc <= '0;
              r_busy    <= 1'b1;
              if (NCHAN == 1) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_state <= SETTLE;
              end
            end else if (CfgWe && (int'(CfgChan) < NCHAN)) begin
              r_delays[CfgChan] <= clamp_delay(CfgDelay);
            end
          end
          SETTLE: begin
            if (r_tmr == TBITS'(SETTLE_CYC - 1)) begin
              r_tmr   <= '0;
              r_state <= COUNT;
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          COUNT: begin
            if (w_expired)
              r_state <= EVAL;
          end
          EVAL: begin
            if (r_d < DBITS'(NREGS - 1)) begin
              r_best        <= w_fin_best;
              r_bestd       <= w_fin_bestd;
              r_d           <= r_d + 1'b1;
              r_delays[r_c] <= r_d + 1'b1;
              r_state       <= SETTLE;
            end else begin
              r_delays[r_c]  <= w_fin_bestd;
              r_nocoinc[r_c] <= (w_fin_best == '0);
              r_best         <= '0;
              r_bestd        <= '0;
              r_d            <= '0;
              if (r_c != CHBITS'(NCHAN - 1)) begin
                r_c                  <= r_c + 1'b1;
                r_delays[r_c + 1'b1] <= '0;
                r_state              <= SETTLE;
              end else begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign Delays  = r_delays;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign NoCoinc = r_nocoinc;

endmodule

// File: doc/delay_calibrator.md
Name: delay_calibrator

Overview:
- Configuration and calibration controller for the per-channel delay-line block in the coincidence detector.
- Owns the per-channel delay-select bus that drives the delay lines.
- Accepts manual host writes while idle.
- On Start, runs an automatic sweep. Channel 0 is the timing reference. Every other channel is stepped through every delay tap, and the block counts coincidences with channel 0 over a programmable window. The tap with the highest count is latched for that channel.

Parameters:
- NCHAN, 4, number of input channels; channel 0 is the reference.
- NREGS, 10, delay-line depth; legal tap indices are 0..NREGS-1.
- DBITS, 4, width of one delay select; 2^DBITS >= NREGS.
- WBITS, 16, width of the count-window length.
- CBITS, 16, width of the coincidence counter; the counter saturates.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  single-cycle request to begin calibration; sampled only in IDLE
- Abort  in  1  abandon calibration and restore the pre-Start delays
- WindowLen  in  WBITS  count-window length in cycles; 0 is treated as 1
- CfgWe  in  1  manual delay write strobe
- CfgChan  in  $clog2(NCHAN)  channel selected for the manual write
- CfgDelay  in  DBITS  delay value for the manual write
- DlayChann  in  NCHAN  delayed channel outputs returned from the delay lines
- Delays  out  NCHAN x DBITS  delay select per channel, driven to the delay lines
- Busy  out  1  calibration in progress
- Done  out  1  one-cycle pulse when calibration completes normally
- NoCoinc  out  NCHAN  per channel: best count was 0; bit 0 always 0

Behaviour:
- Reset: Delays all 0, Busy=0, Done=0, NoCoinc=0, state IDLE, internal counters 0.
- All outputs are registered.

Manual write (IDLE only):
- When CfgWe=1, Delays[CfgChan] <= min(CfgDelay, NREGS-1) on the next edge.
- CfgWe is ignored in every state other than IDLE.
- CfgChan >= NCHAN is ignored.

FSM states and transitions:
- IDLE: Start=1 goes to SETTLE on the next edge. On that edge:
  - snapshot Delays;
  - Delays[0] <= 0, Delays[1] <= 0;
  - set c=1, d=0, best=0, bestd=0;
  - Busy <= 1.
  - If NCHAN==1, go directly to DONE.
- SETTLE: holds for exactly NREGS+2 cycles to flush the delay pipeline, then goes to COUNT with cnt cleared.
- COUNT: holds for max(WindowLen,1) cycles. Each cycle, cnt increments when DlayChann[0] & DlayChann[c]; cnt saturates at 2^CBITS-1. Then goes to EVAL.
- EVAL (one cycle):
  - If cnt > best (strictly greater; ties keep the lower tap), then best <= cnt and bestd <= d.
  - If d < NREGS-1: d++, Delays[c] <= d+1, go to SETTLE.
  - Otherwise: Delays[c] <= final bestd, NoCoinc[c] <= (final best == 0), clear best and bestd.
    - If c < NCHAN-1: c++, Delays[c+1] <= 0, go to SETTLE.
    - Otherwise go to DONE.
- DONE: Done=1 for one cycle, Busy <= 0, go to IDLE.

Calibration rules:
- Delays[0] remains 0 after calibration.
- NoCoinc is cleared on Start and only written during EVAL.
- A Start asserted while Busy is ignored.

Abort:
- Takes priority over every other transition in SETTLE, COUNT and EVAL.
- On the next edge: Delays <= snapshot, Busy <= 0, NoCoinc <= 0, Done stays 0, state IDLE.
- Abort in IDLE or DONE is ignored.

Other boundary conditions:
- WindowLen is sampled at the start of each COUNT; changing it mid-window does not affect the current window.
- Reset asserted mid-calibration returns the block to the reset values. There is no snapshot restore on reset.

Latency:
- Total calibration time is (NCHAN-1) x NREGS x (NREGS+2+W+1) + 2 cycles, where W = max(WindowLen,1).

Decomposition:
- Package dlycal_pkg holds:
  - state enum: IDLE, SETTLE, COUNT, EVAL, DONE;
  - localparam SETTLE_CYC = NREGS+2;
  - a clamp function for delay values.
- One sub-module, coinc_window_counter, holds the window down-counter and the saturating coincidence counter.
  - Inputs: Clk, Rst_n, Load, Len, Hit.
  - Outputs: Cnt, Expired.
- The FSM, snapshot register and Delays register file stay in delay_calibrator.

Test Plan:
- Reset, then manual writes CfgChan=2/CfgDelay=5 and CfgChan=1/CfgDelay=15 -> Delays[2]=5 and Delays[1]=9 (clamped). CfgWe while Busy -> no change.
- Channel 1 carries the same pseudo-random pulses as channel 0 but 3 cycles earlier; channels 2 and 3 idle; WindowLen=200 -> Done after the computed latency, Delays[1]=3, Delays[2]=0, Delays[3]=0, NoCoinc=4'b1100.
- Channels 1, 2 and 3 lead channel 0 by 0, 7 and 9 cycles respectively -> Delays = {9,7,0,0} for channels {3,2,1,0}, NoCoinc=0.
- Periodic pulses on all channels so that taps 2 and 6 give equal counts -> selected tap is 2 (tie rule). A window long enough to exceed 2^CBITS-1 hits -> cnt saturates with no wrap.
- Set Delays={4,3,2,1} manually, Start, Abort during COUNT of channel 2 -> next cycle Delays={4,3,2,1}, Busy=0, Done never pulses, NoCoinc=0.
- Assert Rst_n=0 mid-SETTLE -> Delays all 0, Busy=0 immediately. Start with WindowLen=0 -> every window lasts 1 cycle and total latency matches W=1.
